pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed ID/EX-style latch into a reusable stage between any two CPU pipeline stages. It carries a control bundle and a data bundle with a valid/ready handshake, and uses a two-entry skid buffer so that `in_ready` is registered and back-pressure never creates a combinational path. It supports a synchronous flush that turns the stage into a bubble with all-zero control, plus a saturating stall-cycle counter for performance debug.

## Interface
- `CTRL_W`, default 16: width of the control bundle (RegWrite, MemToReg, WREN/RDEN, ALU op, etc.). All-zero is a NOP.
- `DATA_W`, default 128: width of the data bundle (operands, immediate, register addresses).
- `CNT_W`, default 16: width of the stall counter.
- `clock`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `flush`, in, 1: synchronous flush; empties the stage.
- `in_valid`, in, 1: upstream holds a valid entry.
- `in_ready`, out, 1: stage can accept; registered.
- `in_ctrl`, in, CTRL_W: upstream control bundle.
- `in_data`, in, DATA_W: upstream data bundle.
- `out_valid`, out, 1: the stage presents a valid entry.
- `out_ready`, in, 1: downstream accepts.
- `out_ctrl`, out, CTRL_W: control of the head entry; all-zero whenever `out_valid`=0.
- `out_data`, out, DATA_W: data of the head entry; zero after reset or flush, otherwise holds its last value when empty.
- `occupancy`, out, 2: entries held (0, 1 or 2).
- `stall_cnt`, out, CNT_W: cycles with `out_valid` && !`out_ready`, saturating.

## Operation
- The stage has two storage slots: the main slot drives the outputs, and the skid slot absorbs one entry while back-pressured.
- States: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full).
- `in_ready` = (state != TWO). `out_valid` = (state != EMPTY).
- Accept = `in_valid` && `in_ready`. Pop = `out_valid` && `out_ready`.
- EMPTY with accept: main <= in, go to ONE.
- ONE with accept and pop: main <= in, stay in ONE.
- ONE with accept and no pop: skid <= in, go to TWO.
- ONE with pop and no accept: go to EMPTY; main ctrl <= 0.
- TWO with pop: main <= skid, go to ONE. Accept cannot occur in TWO.
- Entries leave in the order they arrived. No entry is duplicated or lost except by flush.
- Flush (when `reset`=0) has priority over every other event and goes to EMPTY.
  - Main and skid ctrl and data are cleared to zero.
  - An accept or pop in the flush cycle is discarded; upstream treats it as consumed.
- `stall_cnt` increments when `out_valid` && !`out_ready`, holds at 2^CNT_W−1, and is cleared only by reset, not by flush.
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0, skid slot zero.

## Timing
- Latency: an entry accepted at edge N appears on `out_*` after edge N when the stage was EMPTY.
- Full throughput is one entry per cycle with `out_ready` held at 1.
- `in_ready` depends only on registered state; there is no combinational path from `out_ready` to `in_ready`.
- `out_valid`, `out_ctrl` and `out_data` are register outputs.
- `in_ready` falls one cycle after `out_ready` falls, and only if the stage was ONE and accepted without popping. The skid slot absorbs that one in-flight entry.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first accept is possible at the first rising edge after `reset` deasserts.
- Flush and reset together: reset wins.

## Test plan
- Reset then stream: with `out_ready`=1, drive ctrl 0x0001..0x0005 with `in_valid`=1 for 5 cycles. Expect `out_ctrl` 1..5 on consecutive cycles one cycle later, `occupancy` ≤1 and `stall_cnt`=0.
- Skid fill: hold `out_ready`=0 and push A then B. Expect `occupancy`=2, `in_ready`=0, and `out_ctrl`=A held. Then raise `out_ready` for 2 cycles: expect A then B out, `in_ready` back to 1 after the first pop.
- Flush while TWO, with `in_valid`=1 in the same cycle: next cycle expect `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0. The offered entry never appears.
- Bubble: drain to EMPTY. Expect `out_ctrl`=0 while `out_data` keeps its last value.
- Stall counter: with CNT_W=4, hold a valid entry with `out_ready`=0 for 20 cycles. Expect `stall_cnt`=15 (saturated). A flush leaves it at 15; reset returns it to 0.
- Async reset mid-burst: assert `reset` between clock edges while in TWO. Expect all outputs at reset values before the next edge.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake and bundle signals between a pipeline stage register and its neighbours.
// The slave modport is the stage's own view; master is the surrounding pipeline's view.
interface pipe_stage_reg_if #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: main slot plus one skid slot so in_ready is registered,
// synchronous flush to an all-zero bubble, and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input logic           clock,
    input logic           reset,
    pipe_stage_reg_if.slave bus
);
    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept, pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_d     = stall_q;
        accept      = bus.in_valid && (state_q != StTwo);
        pop         = (state_q != StEmpty) && bus.out_ready;

        // Stall counting is independent of flush; only reset clears it.
        if ((state_q != StEmpty) && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (bus.flush) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                        state_d     = StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                    end else if (accept) begin
                        skid_ctrl_d = bus.in_ctrl;
                        skid_data_d = bus.in_data;
                        state_d     = StTwo;
                    end else if (pop) begin
                        // Data is kept so out_data shows the last entry during a bubble.
                        main_ctrl_d = '0;
                        state_d     = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        in_ready_d  = (state_d != StTwo);
        out_valid_d = (state_d != StEmpty);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = main_ctrl_q;
    assign bus.out_data  = main_data_q;
    assign bus.occupancy = state_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int          CNT_MAX = 15;

    logic clock;
    logic reset;

    pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic [DATA_W-1:0] m_last_data;
    int                m_stall;
    int                n_checks;
    int                n_pass;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    endtask

    task automatic model_clear();
        mq.delete();
        m_last_data = '0;
        m_stall     = 0;
    endtask

    // Every output compared against what the queue model says it must be.
    task automatic compare_all();
        int sz;
        sz = mq.size();
        check("out_valid", 64'(bus.out_valid), 64'(sz > 0));
        check("in_ready", 64'(bus.in_ready), 64'(sz < 2));
        check("occupancy", 64'(bus.occupancy), 64'(sz));
        check("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
        check("out_ctrl", 64'(bus.out_ctrl), (sz > 0) ? 64'(mq[0].c) : 64'd0);
        check("out_data", 64'(bus.out_data), (sz > 0) ? 64'(mq[0].d) : 64'(m_last_data));
    endtask

    task automatic model_step(input logic v, input logic [CTRL_W-1:0] c,
                              input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        logic acc, pp;
        ent_t e;
        acc = v && (mq.size() < 2);
        pp  = (mq.size() > 0) && ordy;
        if ((mq.size() > 0) && !ordy && (m_stall < CNT_MAX)) m_stall++;
        if (fl) begin
            mq.delete();
            m_last_data = '0;
        end else begin
            if (pp) begin
                m_last_data = mq[0].d;
                void'(mq.pop_front());
            end
            if (acc) begin
                e.c = c;
                e.d = d;
                mq.push_back(e);
            end
        end
    endtask

    // Drive one cycle, compare at the falling edge, advance the model at the rising edge.
    task automatic cyc(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_step(v, c, d, ordy, fl);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        idle_inputs();
        model_clear();
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_occupancy", 64'(bus.occupancy), 64'd0);
        check("rst_stall", 64'(bus.stall_cnt), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Stream 1..5 at full throughput.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, CTRL_W'(i), DATA_W'(32'h1000 + i), 1'b1, 1'b0);
            check("stream_ctrl", 64'(bus.out_ctrl), 64'(i));
            check("stream_occ", 64'(bus.occupancy), 64'd1);
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_stall", 64'(bus.stall_cnt), 64'd0);
        check("stream_drain_valid", 64'(bus.out_valid), 64'd0);

        // Skid fill with A then B under back-pressure.
        cyc(1'b1, 16'h00aa, 32'haaaa_0001, 1'b0, 1'b0);
        cyc(1'b1, 16'h00bb, 32'hbbbb_0002, 1'b0, 1'b0);
        check("skid_occ", 64'(bus.occupancy), 64'd2);
        check("skid_in_ready", 64'(bus.in_ready), 64'd0);
        check("skid_head", 64'(bus.out_ctrl), 64'h00aa);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("skid_second", 64'(bus.out_ctrl), 64'h00bb);
        check("skid_ready_back", 64'(bus.in_ready), 64'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("bubble_data", 64'(bus.out_data), 64'hbbbb_0002);

        // Flush while TWO with a simultaneous offer.
        cyc(1'b1, 16'h0011, 32'h1111_1111, 1'b0, 1'b0);
        cyc(1'b1, 16'h0022, 32'h2222_2222, 1'b0, 1'b0);
        cyc(1'b1, 16'h0033, 32'h3333_3333, 1'b0, 1'b1);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("flush_data", 64'(bus.out_data), 64'd0);
        check("flush_occ", 64'(bus.occupancy), 64'd0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall counter saturation; survives flush, cleared by reset.
        do_reset();
        cyc(1'b1, 16'h0077, 32'h7777_7777, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        check("stall_sat", 64'(bus.stall_cnt), 64'd15);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check("stall_after_flush", 64'(bus.stall_cnt), 64'd15);
        do_reset();
        check("stall_after_reset", 64'(bus.stall_cnt), 64'd0);

        // Asynchronous reset between edges while TWO.
        cyc(1'b1, 16'h0044, 32'h4444_4444, 1'b0, 1'b0);
        cyc(1'b1, 16'h0055, 32'h5555_5555, 1'b0, 1'b0);
        check("pre_async_occ", 64'(bus.occupancy), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_occ", 64'(bus.occupancy), 64'd0);
        check("async_valid", 64'(bus.out_valid), 64'd0);
        check("async_ready", 64'(bus.in_ready), 64'd1);
        check("async_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("async_data", 64'(bus.out_data), 64'd0);
        check("async_stall", 64'(bus.stall_cnt), 64'd0);
        model_clear();
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom), DATA_W'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
